// File: rtl/adam_disk_pkg.sv
`default_nettype none
// ============================================================================
// Package     : adam_disk_pkg
// Description : Shared sector geometry, cache state encoding and per-way tag
//               record for the ADAM disk sector cache.
// Revision    : 1.0 - initial release
// ============================================================================
package adam_disk_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_SHIFT = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_WB     = 3'd2,
    ST_RD     = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_DONE   = 3'd5
  } cache_state_t;

  typedef struct packed {
    logic        valid;
    logic        dirty;
    logic [31:0] tag;
  } way_tag_t;

endpackage
`default_nettype wire

// File: rtl/sector_cache_ram.sv
`default_nettype none
// ============================================================================
// Module      : sector_cache_ram
// Description : Single-clock true dual-port byte RAM holding the cached
//               sectors. Both ports read with one cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module sector_cache_ram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic [AW-1:0] a_addr,
    input  logic          a_we,
    input  logic [7:0]    a_din,
    output logic [7:0]    a_dout,
    input  logic [AW-1:0] b_addr,
    input  logic          b_we,
    input  logic [7:0]    b_din,
    output logic [7:0]    b_dout
);

    localparam int DEPTH = 1 << AW;

    logic [7:0] mem_q [DEPTH];

    // One process owns the array; port B wins a same-address write collision.
    always_ff @(posedge clk) begin
        if (a_we) mem_q[a_addr] <= a_din;
        if (b_we) mem_q[b_addr] <= b_din;
        a_dout <= mem_q[a_addr];
        b_dout <= mem_q[b_addr];
    end

endmodule
`default_nettype wire

// File: rtl/sector_cache_adam.sv
`default_nettype none
// ============================================================================
// Module      : sector_cache_adam
// Description : Fully associative write-back cache of 512-byte disk sectors
//               in front of an SD block interface, with flush and image
//               mount handling.
// Revision    : 1.0 - initial release
// ============================================================================
module sector_cache_adam
  import adam_disk_pkg::*;
#(
  parameter int DRIVE_NUM = 0,
  parameter int NUM_WAYS  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic [63:0] img_size,
  output logic [31:0] lba_fdd,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic        sd_buff_wr,
  input  logic [7:0]  sd_buff_dout,
  output logic [7:0]  sd_buff_din,
  output logic        disk_present,
  input  logic [31:0] disk_sector,
  input  logic        disk_load,
  output logic        disk_sector_loaded,
  input  logic [8:0]  disk_addr,
  input  logic        disk_wr,
  input  logic        disk_flush,
  output logic        disk_error,
  input  logic [7:0]  disk_din,
  output logic [7:0]  disk_data
);

  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int RAM_AW = SECTOR_SHIFT + $clog2(NUM_WAYS);
  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);

  cache_state_t     state_q, state_d;
  way_tag_t         tags_q [NUM_WAYS];
  way_tag_t         tags_d [NUM_WAYS];
  logic [WAY_W-1:0] rr_q, rr_d;
  logic [WAY_W-1:0] cur_way_q, cur_way_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [WAY_W-1:0] flush_idx_q, flush_idx_d;
  logic             flush_mode_q, flush_mode_d;
  logic             abort_q, abort_d;
  logic             ack_seen_q, ack_seen_d;
  logic             sd_rd_q, sd_rd_d;
  logic             sd_wr_q, sd_wr_d;
  logic [31:0]      lba_q, lba_d;
  logic             loaded_q, loaded_d;
  logic             error_q, error_d;
  logic             present_q, present_d;
  logic [63:0]      size_q, size_d;

  logic             w_hit;
  logic [WAY_W-1:0] w_hit_way;
  logic             w_inv_found;
  logic [WAY_W-1:0] w_inv_way;
  logic [WAY_W-1:0] w_victim;
  logic             w_out_of_range;
  logic             w_xfer_state;
  logic             w_xfer_done;
  logic [WAY_W+8:0] w_a_full;
  logic [WAY_W+8:0] w_b_full;

  function automatic logic [WAY_W-1:0] next_way(input logic [WAY_W-1:0] w);
    return (w == LAST_WAY) ? '0 : w + WAY_W'(1);
  endfunction

  // Tag match and lowest-numbered invalid way; the descending loop lets the
  // lowest index win.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (tags_q[i].valid && (tags_q[i].tag == disk_sector)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(i);
      end
      if (!tags_q[i].valid) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(i);
      end
    end
  end

  assign w_victim       = w_inv_found ? w_inv_way : rr_q;
  assign w_out_of_range = ((64'(disk_sector) << SECTOR_SHIFT) >= size_q);
  assign w_xfer_state   = (state_q == ST_WB) || (state_q == ST_RD);
  // Falling edge of sd_ack after it has been seen high ends a transfer.
  assign w_xfer_done    = w_xfer_state && ack_seen_q && !sd_ack;

  // Next-state, tag and handshake logic.
  always_comb begin
    state_d      = state_q;
    tags_d       = tags_q;
    rr_d         = rr_q;
    cur_way_d    = cur_way_q;
    victim_d     = victim_q;
    flush_idx_d  = flush_idx_q;
    flush_mode_d = flush_mode_q;
    abort_d      = abort_q;
    ack_seen_d   = ack_seen_q;
    sd_rd_d      = sd_rd_q;
    sd_wr_d      = sd_wr_q;
    lba_d        = lba_q;
    loaded_d     = loaded_q;
    error_d      = error_q;
    present_d    = present_q;
    size_d       = size_q;

    // Host writes only count while a sector is presented.
    if (disk_wr && loaded_q) tags_d[cur_way_q].dirty = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (disk_load) begin
          loaded_d = 1'b0;
          error_d  = 1'b0;
          state_d  = ST_LOOKUP;
        end else if (disk_flush) begin
          flush_idx_d = '0;
          state_d     = ST_FLUSH;
        end
      end

      ST_LOOKUP: begin
        if (!present_q || w_out_of_range) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end else if (w_hit) begin
          cur_way_d = w_hit_way;
          loaded_d  = 1'b1;
          state_d   = ST_DONE;
        end else begin
          victim_d     = w_victim;
          flush_mode_d = 1'b0;
          ack_seen_d   = 1'b0;
          if (!w_inv_found) rr_d = next_way(rr_q);
          if (tags_q[w_victim].dirty) begin
            lba_d   = tags_q[w_victim].tag;
            sd_wr_d = 1'b1;
            state_d = ST_WB;
          end else begin
            lba_d   = disk_sector;
            sd_rd_d = 1'b1;
            state_d = ST_RD;
          end
        end
      end

      ST_WB, ST_RD: begin
        if (sd_ack) begin
          sd_rd_d    = 1'b0;
          sd_wr_d    = 1'b0;
          ack_seen_d = 1'b1;
        end else if (ack_seen_q) begin
          ack_seen_d = 1'b0;
          if (abort_q) begin
            abort_d = 1'b0;
            state_d = ST_IDLE;
          end else if (state_q == ST_WB) begin
            tags_d[victim_q].dirty = 1'b0;
            if (flush_mode_q) begin
              if (victim_q == LAST_WAY) begin
                state_d = ST_DONE;
              end else begin
                flush_idx_d = victim_q + WAY_W'(1);
                state_d     = ST_FLUSH;
              end
            end else begin
              lba_d   = disk_sector;
              sd_rd_d = 1'b1;
              state_d = ST_RD;
            end
          end else begin
            tags_d[victim_q].valid = 1'b1;
            tags_d[victim_q].dirty = 1'b0;
            tags_d[victim_q].tag   = disk_sector;
            cur_way_d = victim_q;
            loaded_d  = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end

      ST_FLUSH: begin
        if (tags_q[flush_idx_q].valid && tags_q[flush_idx_q].dirty) begin
          victim_d     = flush_idx_q;
          flush_mode_d = 1'b1;
          ack_seen_d   = 1'b0;
          lba_d        = tags_q[flush_idx_q].tag;
          sd_wr_d      = 1'b1;
          state_d      = ST_WB;
        end else if (flush_idx_q == LAST_WAY) begin
          state_d = ST_DONE;
        end else begin
          flush_idx_d = flush_idx_q + WAY_W'(1);
        end
      end

      ST_DONE: begin
        if (!disk_load && !disk_flush) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // A new image invalidates everything; an in-flight SD transfer is allowed
    // to finish but its result is thrown away.
    if (img_mounted) begin
      size_d    = img_size;
      present_d = |img_size;
      loaded_d  = 1'b0;
      for (int i = 0; i < NUM_WAYS; i++) begin
        tags_d[i].valid = 1'b0;
        tags_d[i].dirty = 1'b0;
      end
      if (w_xfer_state) begin
        if (w_xfer_done) begin
          abort_d = 1'b0;
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          abort_d = 1'b1;
        end
      end else if ((state_q == ST_LOOKUP) || (state_q == ST_FLUSH)) begin
        sd_rd_d = 1'b0;
        sd_wr_d = 1'b0;
        error_d = error_q;
        state_d = ST_IDLE;
      end
    end
  end

  // State and tag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      for (int i = 0; i < NUM_WAYS; i++) tags_q[i] <= '0;
      rr_q         <= '0;
      cur_way_q    <= '0;
      victim_q     <= '0;
      flush_idx_q  <= '0;
      flush_mode_q <= 1'b0;
      abort_q      <= 1'b0;
      ack_seen_q   <= 1'b0;
      sd_rd_q      <= 1'b0;
      sd_wr_q      <= 1'b0;
      lba_q        <= '0;
      loaded_q     <= 1'b0;
      error_q      <= 1'b0;
      present_q    <= 1'b0;
      size_q       <= '0;
    end else begin
      state_q      <= state_d;
      tags_q       <= tags_d;
      rr_q         <= rr_d;
      cur_way_q    <= cur_way_d;
      victim_q     <= victim_d;
      flush_idx_q  <= flush_idx_d;
      flush_mode_q <= flush_mode_d;
      abort_q      <= abort_d;
      ack_seen_q   <= ack_seen_d;
      sd_rd_q      <= sd_rd_d;
      sd_wr_q      <= sd_wr_d;
      lba_q        <= lba_d;
      loaded_q     <= loaded_d;
      error_q      <= error_d;
      present_q    <= present_d;
      size_q       <= size_d;
    end
  end

  assign w_a_full = {victim_q, sd_buff_addr};
  assign w_b_full = {cur_way_q, disk_addr};

  sector_cache_ram #(
    .AW (RAM_AW)
  ) u_ram (
    .clk    (clk),
    .a_addr (w_a_full[RAM_AW-1:0]),
    .a_we   (sd_buff_wr & sd_ack),
    .a_din  (sd_buff_dout),
    .a_dout (sd_buff_din),
    .b_addr (w_b_full[RAM_AW-1:0]),
    .b_we   (disk_wr & loaded_q),
    .b_din  (disk_din),
    .b_dout (disk_data)
  );

  assign lba_fdd            = lba_q;
  assign sd_rd              = sd_rd_q;
  assign sd_wr              = sd_wr_q;
  assign disk_present       = present_q;
  assign disk_sector_loaded = loaded_q;
  assign disk_error         = error_q;

endmodule
`default_nettype wire
